// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the processor M stage and one
//   auxiliary requester (PS2 key logger / VGA frame fetcher). The processor
//   owns the port by default; the aux side borrows it for exactly one cycle
//   per req/ack handshake, stalling the processor during that cycle if it
//   also wants the port.
//
//   Optional feature macro: DMEM_ARB_STARVE_EN
//     defined   - saturating starve counter; a blocked aux request is forced
//                 through after STARVE_LIMIT blocked cycles.
//     undefined - aux is granted only in IDLE cycles with proc_req low.
//
// Ports
//   clock, reset           : master clock, async active-high reset
//   proc_req/wren/address/data, proc_q, proc_stall : processor side
//   aux_req/wren/address/data, aux_ack, aux_q      : aux requester side
//   address_dmem, data, wren, q_dmem               : dmem port (dmem is
//                                                    clocked on ~clock)
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        proc_req,
    input  logic        proc_wren,
    input  logic [11:0] proc_address,
    input  logic [31:0] proc_data,
    output logic [31:0] proc_q,
    output logic        proc_stall,
    input  logic        aux_req,
    input  logic        aux_wren,
    input  logic [11:0] aux_address,
    input  logic [31:0] aux_data,
    output logic        aux_ack,
    output logic [31:0] aux_q,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem
);

    typedef enum logic [1:0] {IDLE, AUX, DONE} state_t;

    typedef struct packed {
        logic        wren;
        logic [11:0] address;
        logic [31:0] data;
    } aux_op_t;

    state_t  state, state_nxt;
    aux_op_t shadow;
    logic    force_grant;
    logic    grant;

    // Aux wins an IDLE cycle when the processor is idle, or when it has been
    // blocked long enough to be forced through.
    assign grant = (state == IDLE) && aux_req && (!proc_req || force_grant);

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] starve_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant)
            starve_cnt <= '0;
        else if (state == IDLE && aux_req && proc_req && starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;
    end

    assign force_grant = (starve_cnt >= 8'(STARVE_LIMIT));
`else
    // No starvation relief; the parameter is kept so both builds share one
    // instantiation interface.
    assign force_grant = 1'b0 & (STARVE_LIMIT == 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Aux inputs are only looked at on the grant edge; the requester may
    // change them afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (grant)
            shadow <= '{wren: aux_wren, address: aux_address, data: aux_data};
    end

    // dmem read completes on the falling edge inside AUX, so q_dmem is valid
    // at the closing rising edge. For aux writes the captured value is the
    // read-during-write output and carries no meaning.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            aux_q <= '0;
        else if (state == AUX)
            aux_q <= q_dmem;
    end

    always_comb begin
        state_nxt    = state;
        address_dmem = proc_address;
        data         = proc_data;
        wren         = proc_req & proc_wren;
        proc_stall   = 1'b0;
        aux_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (grant)
                    state_nxt = AUX;
            end
            AUX: begin
                address_dmem = shadow.address;
                data         = shadow.data;
                wren         = shadow.wren;
                proc_stall   = proc_req;
                state_nxt    = DONE;
            end
            DONE: begin
                // aux_req is still high here while the requester sees the ack;
                // it must not start a new access.
                aux_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign proc_q = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_req, proc_wren;
    logic [11:0] proc_address;
    logic [31:0] proc_data;
    logic [31:0] proc_q;
    logic        proc_stall;
    logic        aux_req, aux_wren;
    logic [11:0] aux_address;
    logic [31:0] aux_data;
    logic        aux_ack;
    logic [31:0] aux_q;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    dmem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .proc_req(proc_req), .proc_wren(proc_wren), .proc_address(proc_address),
        .proc_data(proc_data), .proc_q(proc_q), .proc_stall(proc_stall),
        .aux_req(aux_req), .aux_wren(aux_wren), .aux_address(aux_address),
        .aux_data(aux_data), .aux_ack(aux_ack), .aux_q(aux_q),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    // dmem model: single port, registered on the falling edge, read-old-data.
    logic [31:0] mem [0:4095];
    always @(negedge clock) begin
        if (wren) mem[address_dmem] <= data;
        q_dmem <= mem[address_dmem];
    end

    typedef struct {
        logic        preq, pwren;
        logic [11:0] paddr;
        logic [31:0] pdata;
        logic        areq, awren;
        logic [11:0] aaddr;
        logic [31:0] adata;
        logic [11:0] e_addr;
        logic        e_wren, e_stall, e_ack;
        logic        c_auxq;
        logic [31:0] e_auxq;
        logic        c_pq;
        logic [31:0] e_pq;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        proc_req = v.preq; proc_wren = v.pwren; proc_address = v.paddr; proc_data = v.pdata;
        aux_req = v.areq; aux_wren = v.awren; aux_address = v.aaddr; aux_data = v.adata;
    endtask

    initial begin
        int stall_at, ack_at, stall_n, ack_n;
        logic [11:0] stall_addr;

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = 32'hDEADBEEF;

        //            preq pw paddr   pdata        areq aw aaddr   adata        e_addr  ew st ak cq e_auxq       cp e_pq
        tv[0]  = '{1'b0,1'b0,12'h005,32'h0,       1'b1,1'b0,12'h010,32'h0,       12'h005,1'b0,1'b0,1'b0,1'b1,32'h0,       1'b0,32'h0};
        tv[1]  = '{1'b0,1'b0,12'h005,32'h0,       1'b1,1'b0,12'h3FF,32'h0,       12'h010,1'b0,1'b0,1'b0,1'b1,32'h0,       1'b1,32'hDEADBEEF};
        tv[2]  = '{1'b0,1'b0,12'h005,32'h0,       1'b1,1'b0,12'h3FF,32'h0,       12'h005,1'b0,1'b0,1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tv[3]  = '{1'b0,1'b0,12'h005,32'h0,       1'b0,1'b0,12'h000,32'h0,       12'h005,1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tv[4]  = '{1'b1,1'b0,12'h040,32'h0,       1'b1,1'b1,12'h020,32'h12345678,12'h040,1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tv[5]  = '{1'b0,1'b0,12'h041,32'h0,       1'b1,1'b1,12'h020,32'h12345678,12'h041,1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tv[6]  = '{1'b0,1'b0,12'h041,32'h0,       1'b1,1'b1,12'h022,32'h0,       12'h020,1'b1,1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tv[7]  = '{1'b1,1'b0,12'h020,32'h0,       1'b0,1'b0,12'h000,32'h0,       12'h020,1'b0,1'b0,1'b1,1'b0,32'h0,       1'b1,32'h12345678};
        tv[8]  = '{1'b0,1'b0,12'h020,32'h0,       1'b0,1'b0,12'h000,32'h0,       12'h020,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0};
        tv[9]  = '{1'b0,1'b0,12'h020,32'h0,       1'b1,1'b0,12'h010,32'h0,       12'h020,1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0};
        tv[10] = '{1'b1,1'b1,12'h030,32'hCAFEF00D,1'b1,1'b0,12'h010,32'h0,       12'h010,1'b0,1'b1,1'b0,1'b0,32'h0,       1'b1,32'hDEADBEEF};
        tv[11] = '{1'b1,1'b1,12'h030,32'hCAFEF00D,1'b0,1'b0,12'h000,32'h0,       12'h030,1'b1,1'b0,1'b1,1'b1,32'hDEADBEEF,1'b1,32'h0};
        tv[12] = '{1'b1,1'b0,12'h030,32'h0,       1'b0,1'b0,12'h000,32'h0,       12'h030,1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF,1'b1,32'hCAFEF00D};

        // Reset state
        reset = 1'b1;
        proc_req = 0; proc_wren = 0; proc_address = 12'h123; proc_data = 0;
        aux_req = 0; aux_wren = 0; aux_address = 0; aux_data = 0;
        #3;
        chk("rst aux_ack", {31'b0, aux_ack}, 32'd0);
        chk("rst proc_stall", {31'b0, proc_stall}, 32'd0);
        chk("rst aux_q", aux_q, 32'd0);
        chk("rst address_dmem", {20'b0, address_dmem}, 32'h123);
        @(posedge clock); #1 reset = 1'b0;

        // Table: idle-bus aux read, aux write under traffic, stall
        for (int i = 0; i < 13; i++) begin
            @(posedge clock); #1 drive(tv[i]);
            #7;
            chk($sformatf("v%0d address_dmem", i), {20'b0, address_dmem}, {20'b0, tv[i].e_addr});
            chk($sformatf("v%0d wren", i), {31'b0, wren}, {31'b0, tv[i].e_wren});
            chk($sformatf("v%0d proc_stall", i), {31'b0, proc_stall}, {31'b0, tv[i].e_stall});
            chk($sformatf("v%0d aux_ack", i), {31'b0, aux_ack}, {31'b0, tv[i].e_ack});
            if (tv[i].c_auxq) chk($sformatf("v%0d aux_q", i), aux_q, tv[i].e_auxq);
            if (tv[i].c_pq)   chk($sformatf("v%0d proc_q", i), proc_q, tv[i].e_pq);
        end

        // Starvation: processor and aux both hold their requests
        @(posedge clock); #1;
        proc_req = 1; proc_wren = 0; proc_address = 12'h001;
        aux_req = 1; aux_wren = 0; aux_address = 12'h020;
        stall_at = -1; ack_at = -1; stall_n = 0; ack_n = 0; stall_addr = '0;
`ifdef DMEM_ARB_STARVE_EN
        for (int i = 0; i < 20; i++) begin
            #7;
            if (proc_stall) begin
                if (stall_at < 0) begin stall_at = i; stall_addr = address_dmem; end
                stall_n++;
            end
            if (aux_ack && ack_at < 0) ack_at = i;
            @(posedge clock); #1;
            if (ack_at >= 0) aux_req = 0;
        end
        chk("starve stall cycle", stall_at, 9);
        chk("starve stall count", stall_n, 1);
        chk("starve stall address", {20'b0, stall_addr}, 32'h020);
        chk("starve ack cycle", ack_at, 10);
        chk("starve aux_q", aux_q, 32'h12345678);
`else
        for (int i = 0; i < 1000; i++) begin
            #7;
            if (aux_ack) ack_n++;
            if (proc_stall) stall_n++;
            @(posedge clock); #1;
        end
        chk("nostarve ack count", ack_n, 0);
        chk("nostarve stall count", stall_n, 0);
        proc_req = 0;
        for (int i = 0; i < 5; i++) begin
            #7;
            if (aux_ack && ack_at < 0) ack_at = i;
            @(posedge clock); #1;
            if (ack_at >= 0) aux_req = 0;
        end
        chk("nostarve ack cycle", ack_at, 2);
        chk("nostarve aux_q", aux_q, 32'h12345678);
`endif
        proc_req = 0; aux_req = 0;

        // Reset in the middle of an AUX access
        @(posedge clock); #1;
        aux_req = 1; aux_wren = 0; aux_address = 12'h010;
        @(posedge clock); #1;
        proc_req = 1; proc_wren = 0; proc_address = 12'h0AB;
        #1;
        chk("mid-aux stall", {31'b0, proc_stall}, 32'd1);
        chk("mid-aux address", {20'b0, address_dmem}, 32'h010);
        #1 reset = 1'b1;
        #1;
        chk("reset address_dmem", {20'b0, address_dmem}, 32'h0AB);
        chk("reset proc_stall", {31'b0, proc_stall}, 32'd0);
        chk("reset aux_q", aux_q, 32'd0);
        ack_n = 0;
        if (aux_ack) ack_n++;
        @(posedge clock); #1;
        reset = 1'b0; aux_req = 0; proc_req = 0;
        for (int i = 0; i < 4; i++) begin
            #7;
            if (aux_ack) ack_n++;
            @(posedge clock); #1;
        end
        chk("reset no ack", ack_n, 0);
        chk("reset aux_q hold", aux_q, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (`dmem`, clocked on `~clock`) between the processor's memory stage and one auxiliary requester (PS2 key logger or VGA frame fetcher). The processor owns the port by default. The auxiliary side gets single-word accesses through a req/ack handshake, and the processor is stalled while the port is lent out. The block sits between `processor`/aux logic and `my_dmem` in `skeleton`.

## Interface
- `STARVE_LIMIT`, 8: consecutive blocked cycles before the aux request is forced through (1..255).
- `clock` in 1: master clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `proc_req` in 1: processor memory op valid this cycle (lw/sw in M stage).
- `proc_wren` in 1: processor write enable.
- `proc_address` in 12: processor word address.
- `proc_data` in 32: processor store data.
- `proc_q` out 32: read data to processor.
- `proc_stall` out 1: processor must hold its M stage.
- `aux_req` in 1: aux access request; held until `aux_ack`.
- `aux_wren` in 1: aux write enable.
- `aux_address` in 12: aux word address.
- `aux_data` in 32: aux write data.
- `aux_ack` out 1: one-cycle completion pulse.
- `aux_q` out 32: registered aux read data.
- `address_dmem` out 12: to dmem.
- `data` out 32: to dmem.
- `wren` out 1: to dmem.
- `q_dmem` in 32: from dmem.

## Operation
- FSM states are IDLE, AUX and DONE.
- **IDLE:**
  - Port = processor: `address_dmem`=`proc_address`, `data`=`proc_data`, `wren`=`proc_req & proc_wren`. `proc_stall`=0.
  - If `aux_req & ~proc_req`, go to AUX.
  - If `aux_req & proc_req & force`, go to AUX.
  - On either transition, latch `aux_address`, `aux_wren` and `aux_data` into shadow registers and clear the starve counter.
- **AUX:**
  - Port = shadow registers.
  - `proc_stall` = `proc_req`.
  - At the end of the cycle, capture `q_dmem` into `aux_q` and go to DONE.
- **DONE:**
  - Port = processor, as in IDLE. `proc_stall`=0. `aux_ack`=1.
  - `aux_req` is ignored in DONE; the requester drops it this cycle.
  - Go to IDLE.
- `proc_q` = `q_dmem` always. This is combinational, since dmem read completes on the falling edge within the cycle.
- **Starve counter:**
  - 8-bit, saturating.
  - Increments in IDLE when `aux_req & proc_req`.
  - Cleared on entry to AUX.
  - `force` = (counter ≥ `STARVE_LIMIT`). `force` is only active with the configuration macro defined.
- `aux_q` updates on every AUX completion, including writes (value then = dmem read-during-write output, don't care). It otherwise holds.

## Timing
- **Reset values:** state IDLE, counter 0, shadow regs 0, `aux_q`=0, `aux_ack`=0, `proc_stall`=0. The port outputs follow the processor path combinationally.
- **Aux latency:** `aux_req` sampled high in IDLE at edge N → AUX in cycle N+1 → `aux_ack` high in cycle N+2, with `aux_q` valid from cycle N+2. Minimum 2 cycles from request to ack.
- **Back-to-back aux:**
  - A new request is taken no earlier than the IDLE cycle after DONE, so the minimum aux period is 3 cycles.
  - The processor always wins at least 2 of every 3 cycles.
- **Processor stall:** at most 1 cycle per aux access. The stall is asserted combinationally during AUX only.
- **Simultaneous requests** in IDLE with `force`=0: the processor wins and the aux waits.
- Aux inputs may change after latching; they have no effect until the next grant.
- **Reset mid-AUX:** the access is abandoned, no `aux_ack` is issued, and the port reverts to the processor path immediately (asynchronous).

## Configuration
- The macro `DMEM_ARB_STARVE_EN` controls starvation prevention.
- **Defined:** the starvation counter and `force` are compiled in. A blocked aux request is granted after `STARVE_LIMIT` blocked cycles even while `proc_req`=1.
- **Undefined:** no counter, `force`≡0. Aux is granted only in IDLE cycles where `proc_req`=0, so it may wait indefinitely. `proc_stall` can still assert if `proc_req` rises while in AUX.

## Test plan
- **Reset:** assert `reset` mid-AUX → state IDLE immediately, `aux_ack` never pulses, `aux_q`=0, and `address_dmem` equals `proc_address`.
- **Idle-bus aux read:** dmem[0x010]=0xDEADBEEF, `proc_req`=0, `aux_req`=1 with address 0x010 → `address_dmem`=0x010 in cycle N+1, then `aux_ack`=1 and `aux_q`=0xDEADBEEF in N+2, with `proc_stall` never asserted.
- **Aux write under processor traffic:** aux writes 0x12345678 to 0x020 while `proc_req` toggles 1,0 → the write occurs in the AUX cycle, and a subsequent processor lw at 0x020 returns 0x12345678 on `proc_q`.
- **Stall:** `proc_req`=1 rises during AUX → `proc_stall`=1 for exactly that cycle, and the processor's sw to 0x030 is not written until the DONE/IDLE cycle.
- **Starvation with `DMEM_ARB_STARVE_EN`, `STARVE_LIMIT`=8:** `proc_req` held at 1 and `aux_req` held at 1 → AUX entered after 8 blocked cycles, `proc_stall`=1 for one cycle, `aux_ack` 2 cycles later.
- **Starvation without the macro:** same stimulus for 1000 cycles → `aux_ack` never asserts. Dropping `proc_req` then yields `aux_ack` 2 cycles later.
